// File: rtl/multicycle_ctrl.sv
// Multicycle main-control FSM: decodes the IR opcode and sequences
// datapath strobes and mux selects, stalling memory states on mem_ready.
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9
  } state_t;

  state_t cur, nxt;

  logic is_mem, is_r, is_beq, is_j;

  assign is_mem = (op == OP_LW) || (op == OP_SW);
  assign is_r   = (op == OP_RTYPE);
  assign is_beq = (op == OP_BEQ);
  assign is_j   = (op == OP_J);
  assign state  = cur;

  always_ff @(posedge clk) begin
    if (rst) cur <= FETCH;
    else     cur <= nxt;
  end

  always_comb begin
    nxt         = FETCH;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    illegal_op  = 1'b0;
    case (cur)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        nxt     = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // branch target precomputed here while op is decoded
        ALUSrcB = 2'b11;
        unique case (1'b1)
          is_mem:  nxt = MEMADR;
          is_r:    nxt = EXEC;
          is_beq:  nxt = BRANCH;
          is_j:    nxt = JUMP;
          default: illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nxt     = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        nxt     = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        nxt      = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        nxt     = RWB;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: nxt = FETCH;
    endcase
    // an abandoned instruction must not write anything in the reset cycle
    if (rst) begin
      ALUOp       = 2'b00;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      illegal_op  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle vector table
// through a scoreboard queue, plus instruction latency sequences.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       mem_ready;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       IRWrite, RegDst, MemtoReg, RegWrite, illegal_op;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] R  = 6'b000000;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100;
  localparam logic [5:0] JJ = 6'b000010;
  localparam logic [5:0] XX = 6'b111111;

  // {ALUOp,SrcA,SrcB,PCSrc,PCW,PCWC,IorD,MRd,MWr,IRW,RDst,M2R,RW,ill}
  localparam logic [16:0] F1  = 17'b00_0_01_00_1_0_0_1_0_1_0_0_0_0;
  localparam logic [16:0] F0  = 17'b00_0_01_00_0_0_0_1_0_0_0_0_0_0;
  localparam logic [16:0] DC  = 17'b00_0_11_00_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] DCI = 17'b00_0_11_00_0_0_0_0_0_0_0_0_0_1;
  localparam logic [16:0] MA  = 17'b00_1_10_00_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] MR  = 17'b00_0_00_00_0_0_1_1_0_0_0_0_0_0;
  localparam logic [16:0] MB  = 17'b00_0_00_00_0_0_0_0_0_0_0_1_1_0;
  localparam logic [16:0] MW  = 17'b00_0_00_00_0_0_1_0_1_0_0_0_0_0;
  localparam logic [16:0] EX  = 17'b10_1_00_00_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] RB  = 17'b00_0_00_00_0_0_0_0_0_0_1_0_1_0;
  localparam logic [16:0] BR  = 17'b01_1_00_01_0_1_0_0_0_0_0_0_0_0;
  localparam logic [16:0] JP  = 17'b00_0_00_10_1_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] RS  = 17'b00_0_00_00_0_0_0_0_0_0_0_0_0_0;
  localparam logic [16:0] ALL = 17'h1ffff;
  // reset only pins ALUOp and the strobes; mux selects are free
  localparam logic [16:0] RSM = 17'b11_0_00_00_1_1_0_1_1_1_0_0_1_1;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic        chk_st;
    logic [3:0]  st;
    logic [16:0] mask;
    logic [16:0] outs;
  } vec_t;

  typedef struct {
    int          row;
    logic        chk_st;
    logic [3:0]  st;
    logic [16:0] mask;
    logic [16:0] outs;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic [16:0] act;
  assign act = {ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite,
                PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                RegDst, MemtoReg, RegWrite, illegal_op};

  function automatic vec_t v(logic r, logic [5:0] o, logic rd,
                             logic cs, logic [3:0] s,
                             logic [16:0] m, logic [16:0] x);
    vec_t t;
    t.rst = r; t.op = o; t.rdy = rd; t.chk_st = cs;
    t.st = s; t.mask = m; t.outs = x;
    return t;
  endfunction

  task automatic check_row();
    exp_t e;
    e = sb.pop_front();
    if (e.chk_st) begin
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL state row %0d: got %0d want %0d",
                 e.row, state, e.st);
      end
    end
    checks++;
    if ((act & e.mask) !== (e.outs & e.mask)) begin
      errors++;
      $display("FAIL outs row %0d: got %b want %b (mask %b)",
               e.row, act, e.outs, e.mask);
    end
    checks++;
    if (MemRead && MemWrite) begin
      errors++;
      $display("FAIL rdwr_excl row %0d: got MemRead=1 MemWrite=1 want not both",
               e.row);
    end
    checks++;
    if (RegWrite && state != 4'd4 && state != 4'd7) begin
      errors++;
      $display("FAIL regwrite_state row %0d: got RegWrite=1 in state %0d want 4/7",
               e.row, state);
    end
  endtask

  initial begin
    int lat_op[5];
    int lat_exp[5];
    int n;
    exp_t e;

    // reset from power-up, then release
    vecs.push_back(v(1, LW, 1, 0, 0, RSM, RS));
    vecs.push_back(v(1, LW, 1, 1, 0, RSM, RS));
    // lw with one MEMRD stall
    vecs.push_back(v(0, LW, 1, 1, 0, ALL, F1));
    vecs.push_back(v(0, LW, 1, 1, 1, ALL, DC));
    vecs.push_back(v(0, LW, 1, 1, 2, ALL, MA));
    vecs.push_back(v(0, LW, 0, 1, 3, ALL, MR));
    vecs.push_back(v(0, LW, 1, 1, 3, ALL, MR));
    vecs.push_back(v(0, LW, 1, 1, 4, ALL, MB));
    // R-type
    vecs.push_back(v(0, R,  1, 1, 0, ALL, F1));
    vecs.push_back(v(0, R,  1, 1, 1, ALL, DC));
    vecs.push_back(v(0, R,  1, 1, 6, ALL, EX));
    vecs.push_back(v(0, R,  1, 1, 7, ALL, RB));
    // beq
    vecs.push_back(v(0, BQ, 1, 1, 0, ALL, F1));
    vecs.push_back(v(0, BQ, 1, 1, 1, ALL, DC));
    vecs.push_back(v(0, BQ, 1, 1, 8, ALL, BR));
    // j
    vecs.push_back(v(0, JJ, 1, 1, 0, ALL, F1));
    vecs.push_back(v(0, JJ, 1, 1, 1, ALL, DC));
    vecs.push_back(v(0, JJ, 1, 1, 9, ALL, JP));
    // illegal opcode
    vecs.push_back(v(0, XX, 1, 1, 0, ALL, F1));
    vecs.push_back(v(0, XX, 1, 1, 1, ALL, DCI));
    // sw: 3 FETCH stalls, 2 MEMWR stalls, 9 cycles total
    vecs.push_back(v(0, SW, 0, 1, 0, ALL, F0));
    vecs.push_back(v(0, SW, 0, 1, 0, ALL, F0));
    vecs.push_back(v(0, SW, 0, 1, 0, ALL, F0));
    vecs.push_back(v(0, SW, 1, 1, 0, ALL, F1));
    vecs.push_back(v(0, SW, 1, 1, 1, ALL, DC));
    vecs.push_back(v(0, SW, 1, 1, 2, ALL, MA));
    vecs.push_back(v(0, SW, 0, 1, 5, ALL, MW));
    vecs.push_back(v(0, SW, 0, 1, 5, ALL, MW));
    vecs.push_back(v(0, SW, 1, 1, 5, ALL, MW));
    // reset mid-store while MEMWR is stalled
    vecs.push_back(v(0, SW, 1, 1, 0, ALL, F1));
    vecs.push_back(v(0, SW, 1, 1, 1, ALL, DC));
    vecs.push_back(v(0, SW, 1, 1, 2, ALL, MA));
    vecs.push_back(v(0, SW, 0, 1, 5, ALL, MW));
    vecs.push_back(v(1, SW, 0, 1, 5, RSM, RS));
    vecs.push_back(v(0, SW, 0, 1, 0, ALL, F0));

    rst = 1'b1; op = LW; mem_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst;
      op = vecs[i].op;
      mem_ready = vecs[i].rdy;
      e.row = i;
      e.chk_st = vecs[i].chk_st;
      e.st = vecs[i].st;
      e.mask = vecs[i].mask;
      e.outs = vecs[i].outs;
      sb.push_back(e);
      #1;
      check_row();
    end

    // latency with mem_ready tied high, from FETCH back to FETCH
    lat_op[0] = LW; lat_exp[0] = 5;
    lat_op[1] = SW; lat_exp[1] = 4;
    lat_op[2] = R;  lat_exp[2] = 4;
    lat_op[3] = BQ; lat_exp[3] = 3;
    lat_op[4] = JJ; lat_exp[4] = 3;
    for (int k = 0; k < 5; k++) begin
      rst = 1'b0;
      mem_ready = 1'b1;
      op = lat_op[k][5:0];
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (state != 4'd0 && n < 20);
      checks++;
      if (n != lat_exp[k]) begin
        errors++;
        $display("FAIL latency op=%b: got %0d cycles want %0d",
                 op, n, lat_exp[k]);
      end
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
